// File: rtl/glm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// glm_pkg : shared FSM state encoding and fb_data pixel-field positions
// Rev 1.0
// ----------------------------------------------------------------------------
package glm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_LATCH   = 2'd2,
    ST_DISPLAY = 2'd3
  } glm_state_e;

  // Field index inside fb_data; bit position = FLD_x * BPC + plane
  localparam int NUM_FLD = 6;
  localparam int FLD_R1  = 5;
  localparam int FLD_G1  = 4;
  localparam int FLD_B1  = 3;
  localparam int FLD_R2  = 2;
  localparam int FLD_G2  = 1;
  localparam int FLD_B2  = 0;

endpackage
`default_nettype wire

// File: rtl/glm_scan_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// glm_scan_if : framebuffer read port (strobe/address out, pixel pair back)
// Rev 1.0
// ----------------------------------------------------------------------------
interface glm_scan_if
  import glm_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int COLS   = 32,
  parameter int BPC    = 4
) ();

  logic                             fb_rd_en;
  logic [ADDR_W+$clog2(COLS)-1:0]   fb_addr;
  logic [NUM_FLD*BPC-1:0]           fb_data;

  modport master (output fb_rd_en, output fb_addr, input fb_data);
  modport slave  (input fb_rd_en, input fb_addr, output fb_data);

endinterface
`default_nettype wire

// File: rtl/glm_bcm_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// glm_bcm_timer : binary-coded-modulation on-time counter (BASE_TIME << plane)
// Rev 1.0
// ----------------------------------------------------------------------------
module glm_bcm_timer
  import glm_pkg::*;
#(
  parameter int BPC       = 4,
  parameter int BASE_TIME = 8,
  parameter int PL_W      = 2
) (
  input  wire            clk,
  input  wire            rst,
  input  wire            load_i,
  input  wire [PL_W-1:0] plane_i,
  output logic           done_o
);

  localparam int MAX_TIME = BASE_TIME << (BPC - 1);
  localparam int CNT_W    = (MAX_TIME > 1) ? $clog2(MAX_TIME) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  // Loading N-1 makes done land on the Nth cycle after the load cycle
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load_i) begin
      cnt_d    = CNT_W'((BASE_TIME << plane_i) - 1);
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done_o = active_q && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/glm_scan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// glm_scan : LED-matrix row scanner, shifts bit planes and drives BCM output
// Rev 1.0
// ----------------------------------------------------------------------------
module glm_scan
  import glm_pkg::*;
#(
  parameter int COLS      = 32,
  parameter int ADDR_W    = 3,
  parameter int BPC       = 4,
  parameter int CLK_DIV   = 1,
  parameter int BASE_TIME = 8
) (
  input  wire               clk,
  input  wire               rst,
  input  wire               enable,
  glm_scan_if.master        fb,
  output logic              GLM_R1,
  output logic              GLM_G1,
  output logic              GLM_B1,
  output logic              GLM_R2,
  output logic              GLM_G2,
  output logic              GLM_B2,
  output logic [ADDR_W-1:0] GLM_ADDR,
  output logic              GLM_CLK,
  output logic              GLM_LAT,
  output logic              GLM_OE,
  output logic              GLM_LED1,
  output logic              GLM_LED2,
  output logic              GLM_LED3,
  output logic              GLM_LED4,
  output logic              frame_done
);

  localparam int COL_W   = $clog2(COLS);
  localparam int PL_W    = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int PH_LAST = 2 * CLK_DIV;
  localparam int PH_W    = $clog2(PH_LAST + 1);

  glm_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [PL_W-1:0]         plane_q, plane_d;
  logic [PH_W-1:0]         ph_q, ph_d;
  logic                    frame_done_d, timer_done;
  logic                    rd_en_q, rd_en_d, sclk_q, sclk_d;
  logic                    lat_q, lat_d, oe_q, oe_d;
  logic [ADDR_W+COL_W-1:0] fb_addr_q;
  logic [ADDR_W-1:0]       glm_addr_q;
  logic [NUM_FLD-1:0]      plane_bits, rgb_q;
  logic                    frame_done_q, led1_q, led2_q, led3_q, led4_q;

  for (genvar k = 0; k < NUM_FLD; k++) begin : g_fld
    logic [BPC-1:0] fld;
    assign fld           = fb.fb_data[k*BPC +: BPC];
    assign plane_bits[k] = fld[plane_q];
  end

  glm_bcm_timer #(
    .BPC       (BPC),
    .BASE_TIME (BASE_TIME),
    .PL_W      (PL_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (state_q == ST_LATCH),
    .plane_i (plane_q),
    .done_o  (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    plane_d      = plane_q;
    ph_d         = ph_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SHIFT;
          row_d   = '0;
          col_d   = '0;
          plane_d = '0;
          ph_d    = '0;
        end
      end
      ST_SHIFT: begin
        if (ph_q == PH_W'(PH_LAST)) begin
          ph_d = '0;
          if (col_q == COL_W'(COLS - 1)) begin
            col_d   = '0;
            state_d = ST_LATCH;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_LATCH: state_d = ST_DISPLAY;
      ST_DISPLAY: begin
        // enable only matters here, once the current plane has been shown
        if (timer_done) begin
          if (plane_q == PL_W'(BPC - 1)) begin
            plane_d      = '0;
            row_d        = row_q + ADDR_W'(1);
            frame_done_d = (row_q == {ADDR_W{1'b1}});
          end else begin
            plane_d = plane_q + PL_W'(1);
          end
          if (enable) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
            row_d   = '0;
            plane_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pins are registered from the next-state view so they line up with state_q
  always_comb begin
    rd_en_d = (state_d == ST_SHIFT) && (ph_d == '0);
    sclk_d  = (state_d == ST_SHIFT) && (ph_d > PH_W'(CLK_DIV));
    lat_d   = (state_d == ST_LATCH);
    oe_d    = (state_d != ST_DISPLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      plane_q      <= '0;
      ph_q         <= '0;
      rd_en_q      <= 1'b0;
      fb_addr_q    <= '0;
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_q         <= 1'b1;
      glm_addr_q   <= '0;
      rgb_q        <= '0;
      frame_done_q <= 1'b0;
      led1_q       <= 1'b0;
      led2_q       <= 1'b0;
      led3_q       <= 1'b0;
      led4_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      plane_q      <= plane_d;
      ph_q         <= ph_d;
      rd_en_q      <= rd_en_d;
      fb_addr_q    <= {row_d, col_d};
      sclk_q       <= sclk_d;
      lat_q        <= lat_d;
      oe_q         <= oe_d;
      if (state_d == ST_LATCH) begin
        glm_addr_q <= row_d;
      end
      if ((state_q == ST_SHIFT) && (ph_q == PH_W'(1))) begin
        rgb_q <= plane_bits;
      end
      frame_done_q <= frame_done_d;
      led1_q       <= enable;
      led2_q       <= led2_q ^ frame_done_d;
      led3_q       <= (state_d == ST_DISPLAY);
      led4_q       <= (state_d == ST_IDLE);
    end
  end

  assign fb.fb_rd_en = rd_en_q;
  assign fb.fb_addr  = fb_addr_q;
  assign GLM_R1      = rgb_q[FLD_R1];
  assign GLM_G1      = rgb_q[FLD_G1];
  assign GLM_B1      = rgb_q[FLD_B1];
  assign GLM_R2      = rgb_q[FLD_R2];
  assign GLM_G2      = rgb_q[FLD_G2];
  assign GLM_B2      = rgb_q[FLD_B2];
  assign GLM_ADDR    = glm_addr_q;
  assign GLM_CLK     = sclk_q;
  assign GLM_LAT     = lat_q;
  assign GLM_OE      = oe_q;
  assign GLM_LED1    = led1_q;
  assign GLM_LED2    = led2_q;
  assign GLM_LED3    = led3_q;
  assign GLM_LED4    = led4_q;
  assign frame_done  = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_glm_scan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_glm_scan : directed bench for glm_scan (4 cols, 2 rows, 2 planes)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_glm_scan;

  localparam int COLS      = 4;
  localparam int ADDR_W    = 1;
  localparam int BPC       = 2;
  localparam int CLK_DIV   = 1;
  localparam int BASE_TIME = 4;
  localparam int NS        = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic r1, g1, b1, r2, g2, b2, gclk, glat, goe;
  logic led1, led2, led3, led4, fdone;
  logic [ADDR_W-1:0] gaddr;

  int errors = 0;
  int checks = 0;

  logic [6*BPC-1:0] mem [8];

  logic       c_rd [NS], c_clk [NS], c_lat [NS], c_oe [NS], c_fd [NS];
  logic       c_r1 [NS], c_g1 [NS], c_g2 [NS], c_b2 [NS];
  logic       c_led1 [NS], c_led2 [NS], c_led3 [NS], c_led4 [NS];
  logic [2:0] c_addr [NS];
  logic [ADDR_W-1:0] c_gaddr [NS];

  glm_scan_if #(.ADDR_W(ADDR_W), .COLS(COLS), .BPC(BPC)) fb_if ();

  glm_scan #(
    .COLS(COLS), .ADDR_W(ADDR_W), .BPC(BPC), .CLK_DIV(CLK_DIV), .BASE_TIME(BASE_TIME)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fb(fb_if),
    .GLM_R1(r1), .GLM_G1(g1), .GLM_B1(b1), .GLM_R2(r2), .GLM_G2(g2), .GLM_B2(b2),
    .GLM_ADDR(gaddr), .GLM_CLK(gclk), .GLM_LAT(glat), .GLM_OE(goe),
    .GLM_LED1(led1), .GLM_LED2(led2), .GLM_LED3(led3), .GLM_LED4(led4),
    .frame_done(fdone)
  );

  always #5 clk = ~clk;

  // Synchronous framebuffer: data appears the cycle after the strobe
  always @(posedge clk) begin
    if (fb_if.fb_rd_en) fb_if.fb_data <= mem[fb_if.fb_addr];
  end

  task automatic start_scan();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
  endtask

  // Sample index s = negedge of the s-th cycle after the IDLE->SHIFT edge
  task automatic capture(input int n, input int drop_at, input int rst_at);
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      c_rd[s] = fb_if.fb_rd_en;   c_addr[s] = fb_if.fb_addr;
      c_clk[s] = gclk;            c_lat[s] = glat;     c_oe[s] = goe;
      c_fd[s] = fdone;            c_gaddr[s] = gaddr;
      c_r1[s] = r1; c_g1[s] = g1; c_g2[s] = g2; c_b2[s] = b2;
      c_led1[s] = led1; c_led2[s] = led2; c_led3[s] = led3; c_led4[s] = led4;
      if (s == drop_at) enable = 1'b0;
      if (s == rst_at) rst = 1'b1;
      if (s == rst_at + 1) rst = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [13:0] zeros;
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    zeros = {r1, g1, b1, r2, g2, b2, gclk, glat, led1, led2, led3, led4, fdone, fb_if.fb_rd_en};
    checks += 4;
    if (goe !== 1'b1) begin errors++; $display("FAIL reset_oe: got %b want 1", goe); end
    if (zeros !== 14'd0) begin errors++; $display("FAIL reset_pins: got %b want 0", zeros); end
    if (fb_if.fb_addr !== 3'd0) begin errors++; $display("FAIL reset_fb_addr: got %0d want 0", fb_if.fb_addr); end
    if (gaddr !== 1'b0) begin errors++; $display("FAIL reset_glm_addr: got %b want 0", gaddr); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (led4 !== 1'b1) begin errors++; $display("FAIL idle_led4: got %b want 1", led4); end
    if (led3 !== 1'b0) begin errors++; $display("FAIL idle_led3: got %b want 0", led3); end
    if (goe !== 1'b1) begin errors++; $display("FAIL idle_oe: got %b want 1", goe); end
    if (fb_if.fb_rd_en !== 1'b0) begin errors++; $display("FAIL idle_rd_en: got %b want 0", fb_if.fb_rd_en); end
  endtask

  task automatic test_shift_timing();
    logic e_clk, e_lat, e_oe;
    int p;
    start_scan();
    capture(80, -1, -1);
    for (int s = 0; s < 39; s++) begin
      p = (s < 17) ? s : s - 17;
      e_clk = (p < 12) && (p % 3 == 2);
      e_lat = (p == 12);
      e_oe  = !((s >= 13 && s <= 16) || (s >= 30 && s <= 37));
      checks += 3;
      if (c_clk[s] !== e_clk) begin errors++; $display("FAIL shift_clk s=%0d: got %b want %b", s, c_clk[s], e_clk); end
      if (c_lat[s] !== e_lat) begin errors++; $display("FAIL latch s=%0d: got %b want %b", s, c_lat[s], e_lat); end
      if (c_oe[s] !== e_oe) begin errors++; $display("FAIL oe s=%0d: got %b want %b", s, c_oe[s], e_oe); end
    end
  endtask

  task automatic test_colour_fetch();
    logic e_rd;
    int   ts [12] = '{2, 11, 19, 28, 2, 19, 5, 8, 22, 25, 40, 57};
    int   tp [12] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 3};
    logic te [12] = '{0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 1, 0};
    logic got;
    start_scan();
    capture(80, -1, -1);
    for (int s = 0; s < 17; s++) begin
      e_rd = (s < 12) && (s % 3 == 0);
      checks++;
      if (c_rd[s] !== e_rd) begin errors++; $display("FAIL rd_en s=%0d: got %b want %b", s, c_rd[s], e_rd); end
      if (e_rd) begin
        checks++;
        if (c_addr[s] !== 3'(s / 3)) begin errors++; $display("FAIL fb_addr s=%0d: got %0d want %0d", s, c_addr[s], s / 3); end
      end
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (c_rd[38 + 3*c] !== 1'b1 || c_addr[38 + 3*c] !== 3'(4 + c)) begin
        errors++;
        $display("FAIL row1_addr c=%0d: got rd=%b addr=%0d want rd=1 addr=%0d", c, c_rd[38 + 3*c], c_addr[38 + 3*c], 4 + c);
      end
    end
    for (int i = 0; i < 12; i++) begin
      case (tp[i])
        0:       got = c_r1[ts[i]];
        1:       got = c_g1[ts[i]];
        2:       got = c_b2[ts[i]];
        default: got = c_g2[ts[i]];
      endcase
      checks++;
      if (got !== te[i]) begin errors++; $display("FAIL colour pin%0d s=%0d: got %b want %b", tp[i], ts[i], got, te[i]); end
    end
  endtask

  task automatic test_frame();
    logic e_fd;
    int   ls [5] = '{12, 29, 50, 67, 88};
    logic la [5] = '{0, 0, 1, 1, 0};
    start_scan();
    capture(160, -1, -1);
    for (int s = 0; s < 160; s++) begin
      e_fd = (s == 76) || (s == 152);
      checks++;
      if (c_fd[s] !== e_fd) begin errors++; $display("FAIL frame_done s=%0d: got %b want %b", s, c_fd[s], e_fd); end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (c_lat[ls[i]] !== 1'b1 || c_gaddr[ls[i]] !== la[i]) begin
        errors++;
        $display("FAIL lat_addr s=%0d: got lat=%b addr=%b want lat=1 addr=%b", ls[i], c_lat[ls[i]], c_gaddr[ls[i]], la[i]);
      end
    end
    checks += 7;
    if (c_led2[75] !== 1'b0) begin errors++; $display("FAIL led2 s=75: got %b want 0", c_led2[75]); end
    if (c_led2[76] !== 1'b1) begin errors++; $display("FAIL led2 s=76: got %b want 1", c_led2[76]); end
    if (c_led2[151] !== 1'b1) begin errors++; $display("FAIL led2 s=151: got %b want 1", c_led2[151]); end
    if (c_led2[152] !== 1'b0) begin errors++; $display("FAIL led2 s=152: got %b want 0", c_led2[152]); end
    if (c_led3[13] !== 1'b1 || c_led3[12] !== 1'b0) begin errors++; $display("FAIL led3: got %b%b want 10", c_led3[13], c_led3[12]); end
    if (c_led4[0] !== 1'b0) begin errors++; $display("FAIL led4 s=0: got %b want 0", c_led4[0]); end
    if (c_led1[5] !== 1'b1) begin errors++; $display("FAIL led1 s=5: got %b want 1", c_led1[5]); end
  endtask

  task automatic test_enable_drop();
    int rd_late, oe_low;
    start_scan();
    capture(60, 4, -1);
    rd_late = 0;
    oe_low  = 0;
    for (int s = 0; s < 60; s++) begin
      if (s >= 17 && c_rd[s] === 1'b1) rd_late++;
      if (c_oe[s] === 1'b0) oe_low++;
    end
    checks += 8;
    if (c_rd[9] !== 1'b1 || c_addr[9] !== 3'd3) begin errors++; $display("FAIL drop_last_col: got rd=%b addr=%0d want rd=1 addr=3", c_rd[9], c_addr[9]); end
    if (c_lat[12] !== 1'b1) begin errors++; $display("FAIL drop_latch: got %b want 1", c_lat[12]); end
    if (c_oe[13] !== 1'b0 || c_oe[16] !== 1'b0) begin errors++; $display("FAIL drop_display: got %b%b want 00", c_oe[13], c_oe[16]); end
    if (oe_low !== 4) begin errors++; $display("FAIL drop_oe_cycles: got %0d want 4", oe_low); end
    if (rd_late !== 0) begin errors++; $display("FAIL drop_rd_after: got %0d want 0", rd_late); end
    if (c_oe[17] !== 1'b1 || c_led4[17] !== 1'b1) begin errors++; $display("FAIL drop_idle: got oe=%b led4=%b want 1 1", c_oe[17], c_led4[17]); end
    if (c_led1[4] !== 1'b1) begin errors++; $display("FAIL drop_led1 s=4: got %b want 1", c_led1[4]); end
    if (c_led1[5] !== 1'b0) begin errors++; $display("FAIL drop_led1 s=5: got %b want 0", c_led1[5]); end
  endtask

  task automatic test_reset_display();
    start_scan();
    capture(70, -1, 52);
    checks += 8;
    if (c_oe[52] !== 1'b0) begin errors++; $display("FAIL rstd_pre_oe: got %b want 0", c_oe[52]); end
    if (c_oe[53] !== 1'b1) begin errors++; $display("FAIL rstd_oe: got %b want 1", c_oe[53]); end
    if (c_b2[52] !== 1'b1 || c_b2[53] !== 1'b0) begin errors++; $display("FAIL rstd_pins: got %b%b want 10", c_b2[52], c_b2[53]); end
    if (c_gaddr[52] !== 1'b1 || c_gaddr[53] !== 1'b0) begin errors++; $display("FAIL rstd_glm_addr: got %b%b want 10", c_gaddr[52], c_gaddr[53]); end
    if (c_rd[53] !== 1'b0) begin errors++; $display("FAIL rstd_rd: got %b want 0", c_rd[53]); end
    if (c_rd[54] !== 1'b1 || c_addr[54] !== 3'd0) begin errors++; $display("FAIL rstd_restart: got rd=%b addr=%0d want rd=1 addr=0", c_rd[54], c_addr[54]); end
    if (c_g1[56] !== 1'b1) begin errors++; $display("FAIL rstd_plane: got %b want 1", c_g1[56]); end
    if (c_g2[56] !== 1'b0) begin errors++; $display("FAIL rstd_row: got %b want 0", c_g2[56]); end
  endtask

  initial begin
    for (int a = 0; a < 8; a++) begin
      mem[a] = {2'b10, 2'b01, 2'b11, 2'b00, 1'b0, a[2], a[1:0]};
    end
    test_reset();
    test_shift_timing();
    test_colour_fetch();
    test_frame();
    test_enable_drop();
    test_reset_display();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
